fp_add_scheduler: RTL

Round-robin scheduler that shares one pipelined `floating_point_adder` among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the adder. It records each issue's requester ID in an in-order tag FIFO and steers every adder result back as a response tagged with that ID. It sits between the FPU clients and the adder, and the adder shares this block's clock and reset.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fp_tag_fifo.sv | 55 +++++
 rtl/fp_add_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: adder status codes, single-precision field layout and width.
package fpu_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } states;

  typedef struct packed {
    logic       sign;
    logic [7:0] exponent;
    logic [22:0] mantissa;
  } float_point_num;

endpackage

// File: rtl/fp_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every operand pair in flight in the adder.
module fp_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when popping, keeping full purely registered.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin front end sharing one pipelined FP adder among N_REQ requesters;
// results are steered back in issue order using the tag FIFO.
module fp_add_scheduler
  import fpu_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int TAG_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ-1:0][FP_W-1:0]  req_a,
  input  logic [N_REQ-1:0][FP_W-1:0]  req_b,
  output logic [N_REQ-1:0]            req_rdy,
  output logic [FP_W-1:0]             add_a,
  output logic [FP_W-1:0]             add_b,
  output logic                        add_vld,
  input  logic [FP_W-1:0]             add_result,
  input  logic [1:0]                  add_state,
  input  logic                        add_res_vld,
  output logic                        rsp_vld,
  output logic [ID_W-1:0]             rsp_id,
  output logic [FP_W-1:0]             rsp_result,
  output logic [1:0]                  rsp_state,
  output logic                        busy,
  output logic                        proto_err
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic            hs;
  logic            tag_full;
  logic            tag_empty;
  logic            tag_pop;
  logic [ID_W-1:0] tag_head;

  // Scan requesters starting at rr_ptr; first valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr;
    cand        = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && req_vld[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  assign hs = grant_found && !tag_full && rst;

  always_comb begin
    req_rdy = '0;
    if (hs)
      req_rdy[grant_id] = 1'b1;
  end

  assign tag_pop = add_res_vld && !tag_empty;
  assign busy    = !tag_empty || add_vld;

  fp_tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (hs),
    .push_data (grant_id),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr     <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_vld    <= 1'b0;
      rsp_vld    <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_state  <= OK;
      proto_err  <= 1'b0;
    end else begin
      add_vld <= hs;
      if (hs) begin
        add_a  <= req_a[grant_id];
        add_b  <= req_b[grant_id];
        rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      rsp_vld <= tag_pop;
      if (tag_pop) begin
        rsp_id     <= tag_head;
        rsp_result <= add_result;
        rsp_state  <= add_state;
      end
      // A result with nothing outstanding means the adder and scheduler lost sync.
      if (add_res_vld && tag_empty)
        proto_err <= 1'b1;
    end
  end

endmodule
